// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame-level FSM that sequences start, data,
// optional parity and stop bits. The bit-period timing comes from an
// internal edge counter. It drives the sampler enable, the deserializer
// shift strobe and the error/valid pulses.
module uart_rx_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  input  logic       sampled_bit,
  input  logic [5:0] prescale,
  input  logic       par_en,
  input  logic       par_typ,
  output logic       data_samp_en,
  output logic       deser_en,
  output logic       error_happened,
  output logic       data_valid,
  output logic       par_err,
  output logic       stp_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] edge_cnt_q, edge_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [4:0] bit_max_q, bit_max_d;   // latched prescale-1
  logic       par_en_q, par_en_d;
  logic       par_typ_q, par_typ_d;
  logic       par_acc_q, par_acc_d;
  logic       par_err_q, par_err_d;
  logic       stp_err_q, stp_err_d;

  logic       bit_end_s;
  logic       deser_en_s;
  logic       error_s;
  logic       valid_s;

  // Map the oversampling ratio to the last edge index of a bit.
  // Unsupported ratios fall back to 8.
  function automatic logic [4:0] decode_bit_max(input logic [5:0] ps);
    logic [4:0] r;
    case (ps)
      6'd16:   r = 5'd15;
      6'd32:   r = 5'd31;
      default: r = 5'd7;
    endcase
    return r;
  endfunction

  // State register and frame context; async reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      edge_cnt_q <= 5'd0;
      bit_cnt_q  <= 3'd0;
      bit_max_q  <= 5'd7;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_acc_q  <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_max_q  <= bit_max_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_acc_q  <= par_acc_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
    end
  end

  // Next-state logic plus the single-cycle strobes issued at each bit end.
  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    bit_max_d  = bit_max_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_acc_d  = par_acc_q;
    par_err_d  = par_err_q;
    stp_err_d  = stp_err_q;
    deser_en_s = 1'b0;
    error_s    = 1'b0;
    valid_s    = 1'b0;
    bit_end_s  = (edge_cnt_q == bit_max_q);

    // The edge counter free-runs inside a frame and wraps at the bit end.
    if (state_q == IDLE) begin
      edge_cnt_d = 5'd0;
    end else if (bit_end_s) begin
      edge_cnt_d = 5'd0;
    end else begin
      edge_cnt_d = edge_cnt_q + 5'd1;
    end

    case (state_q)
      IDLE: begin
        if (!rx_in) begin
          // Start detected: capture the frame format and clear flags.
          state_d   = START;
          bit_cnt_d = 3'd0;
          par_acc_d = 1'b0;
          par_err_d = 1'b0;
          stp_err_d = 1'b0;
          bit_max_d = decode_bit_max(prescale);
          par_en_d  = par_en;
          par_typ_d = par_typ;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          if (sampled_bit) begin
            // Line glitch rather than a real start bit.
            error_s = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          deser_en_s = 1'b1;
          par_acc_d  = par_acc_q ^ sampled_bit;
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          if (sampled_bit != (par_acc_q ^ par_typ_q)) begin
            par_err_d = 1'b1;
            error_s   = 1'b1;
          end else begin
            par_err_d = par_err_q;
          end
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          if (!sampled_bit) begin
            stp_err_d = 1'b1;
            error_s   = 1'b1;
          end else if (!par_err_q) begin
            valid_s = 1'b1;
          end else begin
            valid_s = 1'b0;
          end
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data_samp_en   = (state_q != IDLE);
  assign busy           = (state_q != IDLE);
  assign deser_en       = deser_en_s;
  assign error_happened = error_s;
  assign data_valid     = valid_s;
  assign par_err        = par_err_q;
  assign stp_err        = stp_err_q;

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 rx_in  input  1  raw serial line; idle level is 1.
REQ-004 sampled_bit  input  1  majority-voted bit from the sampler; valid in the cycle where edge_cnt == prescale-1.
REQ-005 prescale  input  6  oversampling ratio; legal values are 8, 16 and 32; any other value is treated as 8.
REQ-006 par_en  input  1  frame carries a parity bit when 1.
REQ-007 par_typ  input  1  parity type: 0 = even, 1 = odd.
REQ-008 data_samp_en  output  1  enables the sampler; equals 1 in every state except IDLE.
REQ-009 deser_en  output  1  one-cycle shift strobe to the deserializer, one per data bit.
REQ-010 error_happened  output  1  one-cycle pulse that clears the deserializer on a start, parity or stop failure.
REQ-011 data_valid  output  1  one-cycle pulse when a frame completes without error.
REQ-012 par_err  output  1  sticky parity-error flag.
REQ-013 stp_err  output  1  sticky stop-error flag.
REQ-014 busy  output  1  frame in progress; equals 1 in every state except IDLE.

Function
REQ-015 States: IDLE, START, DATA, PARITY, STOP; 3-bit state register.
REQ-016 edge_cnt (5 bits) increments every cycle outside IDLE.
- It wraps to 0 at prescale-1.
- bit_end is defined as edge_cnt == prescale-1.
REQ-017 IDLE with rx_in == 0:
- Go to START with edge_cnt = 0.
- Clear par_err, stp_err, bit_cnt and the parity accumulator.
REQ-018 START at bit_end:
- sampled_bit == 0: go to DATA.
- sampled_bit == 1 (glitch): pulse error_happened for one cycle and go to IDLE.
REQ-019 DATA:
- At each bit_end, assert deser_en combinationally in that same cycle and XOR sampled_bit into the parity accumulator.
- bit_cnt (3 bits) increments at each bit_end.
REQ-020 DATA at bit_end with bit_cnt == 7: bit_cnt wraps to 0; go to PARITY if par_en == 1, else STOP.
REQ-021 PARITY at bit_end:
- Expected bit = accumulator XOR par_typ.
- Mismatch: set par_err and pulse error_happened.
- Go to STOP in either case.
REQ-022 STOP at bit_end:
- sampled_bit == 1 and par_err == 0: pulse data_valid for one cycle.
- sampled_bit == 0: set stp_err and pulse error_happened; data_valid stays 0.
- Go to IDLE in all cases.
REQ-023 deser_en is never asserted outside DATA; exactly 8 strobes are issued per accepted start bit.
REQ-024 par_en, par_typ and prescale are sampled on the IDLE->START transition and held for the rest of the frame.
REQ-025 rx_in low in the same cycle that STOP returns to IDLE is not a new start; it is detected on the next cycle.
REQ-026 error_happened and data_valid are never asserted in the same cycle.
REQ-027 par_err and stp_err hold their value until the next start detection or reset.
REQ-028 Frame length in cycles = prescale × (10 + par_en), from the falling edge of rx_in to the IDLE return.

Reset
REQ-029 While rst_n == 0:
- state = IDLE and all counters = 0.
- data_samp_en, deser_en, error_happened, data_valid, par_err, stp_err and busy are all 0.
REQ-030 Reset asserted mid-frame aborts the frame immediately; no error_happened or data_valid pulse is emitted.
REQ-031 After rst_n deasserts, a start bit is detected only on a fresh rx_in == 0 sample.

Verification
REQ-032 prescale = 8, par_en = 0, frame 0xA5, stop = 1 -> 8 deser_en pulses spaced 8 cycles apart, bits LSB first 1,0,1,0,0,1,0,1; one data_valid pulse; no errors.
REQ-033 prescale = 16, par_en = 1, par_typ = 0, data 0x03, parity bit 0 -> data_valid pulse; par_err = 0. Same frame with parity bit 1 -> par_err = 1, one error_happened pulse, no data_valid.
REQ-034 Stop bit driven 0 -> stp_err = 1, one error_happened pulse at the STOP bit_end, return to IDLE.
REQ-035 rx_in low for 2 cycles, with sampled_bit = 1 at the START bit_end -> error_happened pulse, IDLE, zero deser_en pulses.
REQ-036 rst_n pulsed low during data bit 4 -> all outputs 0 immediately; the next clean 0x5A frame is received correctly.
REQ-037 prescale = 32, two frames back to back with no idle gap -> two data_valid pulses and 16 deser_en pulses in total.
